// File: rtl/accelerator_transformer_streamer_pkg.sv
// Shared types and helpers for the transformer matrix operand streamer.
// Pure definitions: no latency, no flow control.
package accelerator_transformer_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    ROW_END,
    DONE
  } stream_state_t;

  // Width used when clamping the requested matrix dimensions.
  localparam int SIZE_W = 64;

  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] v,
                                                   input logic [SIZE_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Row-major address of element (i, j) in a buffer with a fixed row stride.
  function automatic int unsigned elem_addr(input int unsigned i,
                                            input int unsigned j,
                                            input int unsigned stride);
    return i * stride + j;
  endfunction

endpackage

// File: rtl/accelerator_transformer_matrix_buffer.sv
// Operand matrix store: one write port, one combinational read port, no reset.
// Write lands on the clock edge; read has zero latency; never stalls.
module accelerator_transformer_matrix_buffer
  import accelerator_transformer_streamer_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 64,
  parameter int ADDR_SIZE = 6
) (
  input  logic                 core_clk,
  input  logic                 wr_vld,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_dat,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_dat
);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic                 wr_ok;

  // Addresses past the last element are dropped silently.
  generate
    if (DEPTH == (1 << ADDR_SIZE)) begin : g_pow2
      assign wr_ok = wr_vld;
    end else begin : g_np2
      assign wr_ok = wr_vld && (int'(wr_addr) < DEPTH);
    end
  endgenerate

  always_ff @(posedge core_clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/accelerator_standard_transformer_matrix_streamer.sv
// Streams a buffered operand matrix row by row; one element per request, 1-cycle request-to-strobe.
// Paced entirely by the consumer's row/element requests; holds DATA_OUT while no request arrives.
module accelerator_standard_transformer_matrix_streamer
  import accelerator_transformer_streamer_pkg::*;
#(
  parameter int DATA_SIZE  = 64,
  parameter int SIZE_I_MAX = 8,
  parameter int SIZE_J_MAX = 8,
  localparam int ADDR_SIZE = $clog2(SIZE_I_MAX * SIZE_J_MAX)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic                 WR_ENABLE,
  input  logic [ADDR_SIZE-1:0] WR_ADDR,
  input  logic [DATA_SIZE-1:0] WR_DATA,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 DATA_I_ENABLE,
  output logic                 DATA_J_ENABLE,
  input  logic                 DATA_I_REQUEST,
  input  logic                 DATA_J_REQUEST
);

  localparam int DEPTH = SIZE_I_MAX * SIZE_J_MAX;
  localparam int IW    = $clog2(SIZE_I_MAX + 1);
  localparam int JW    = $clog2(SIZE_J_MAX + 1);

  stream_state_t        state;
  logic [IW-1:0]        i_cnt;
  logic [JW-1:0]        j_cnt;
  logic [IW-1:0]        si_last;
  logic [JW-1:0]        sj_last;

  logic [IW-1:0]        si_in_c;
  logic [JW-1:0]        sj_in_c;
  logic                 emit_i;
  logic                 emit_j;
  logic                 go_done;
  logic                 go_row_end;
  logic [IW-1:0]        nxt_i;
  logic [JW-1:0]        nxt_j;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [DATA_SIZE-1:0] rd_dat;
  logic [DATA_SIZE-1:0] emit_dat;

  assign si_in_c = IW'(clamp_size(SIZE_W'(SIZE_I_IN), SIZE_W'(SIZE_I_MAX)));
  assign sj_in_c = JW'(clamp_size(SIZE_W'(SIZE_J_IN), SIZE_W'(SIZE_J_MAX)));

  always_comb begin
    emit_i     = 1'b0;
    emit_j     = 1'b0;
    go_done    = 1'b0;
    go_row_end = 1'b0;
    nxt_i      = i_cnt;
    nxt_j      = j_cnt;
    case (state)
      IDLE: begin
        if (START) begin
          if (si_in_c == '0 || sj_in_c == '0) begin
            go_done = 1'b1;
          end else begin
            emit_i = 1'b1;
            emit_j = 1'b1;
            nxt_i  = '0;
            nxt_j  = '0;
          end
        end
      end
      STREAM, ROW_END: begin
        // Row request wins over element request; ROW_END only listens to rows.
        if (DATA_I_REQUEST) begin
          if (i_cnt < si_last) begin
            emit_i = 1'b1;
            emit_j = 1'b1;
            nxt_i  = i_cnt + IW'(1);
            nxt_j  = '0;
          end else begin
            go_done = 1'b1;
          end
        end else if (DATA_J_REQUEST && state == STREAM) begin
          if (j_cnt < sj_last) begin
            emit_j = 1'b1;
            nxt_j  = j_cnt + JW'(1);
          end else if (i_cnt < si_last) begin
            go_row_end = 1'b1;
          end else begin
            go_done = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rd_addr = ADDR_SIZE'(elem_addr(32'(nxt_i), 32'(nxt_j), SIZE_J_MAX));

  // A write landing on the same edge as the emission must still be seen.
  assign emit_dat = (WR_ENABLE && WR_ADDR == rd_addr) ? WR_DATA : rd_dat;

  accelerator_transformer_matrix_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_buffer (
    .core_clk (CLK),
    .wr_vld   (WR_ENABLE),
    .wr_addr  (WR_ADDR),
    .wr_dat   (WR_DATA),
    .rd_addr  (rd_addr),
    .rd_dat   (rd_dat)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      i_cnt         <= '0;
      j_cnt         <= '0;
      si_last       <= '0;
      sj_last       <= '0;
      READY         <= 1'b0;
      DATA_OUT      <= '0;
      DATA_I_ENABLE <= 1'b0;
      DATA_J_ENABLE <= 1'b0;
    end else begin
      DATA_I_ENABLE <= emit_i;
      DATA_J_ENABLE <= emit_j;
      READY         <= go_done;
      i_cnt         <= nxt_i;
      j_cnt         <= nxt_j;
      if (emit_j) begin
        DATA_OUT <= emit_dat;
      end
      case (state)
        IDLE: begin
          if (START) begin
            si_last <= (si_in_c == '0) ? '0 : si_in_c - IW'(1);
            sj_last <= (sj_in_c == '0) ? '0 : sj_in_c - JW'(1);
            state   <= go_done ? DONE : STREAM;
          end
        end
        STREAM, ROW_END: begin
          if (go_done) begin
            state <= DONE;
          end else if (go_row_end) begin
            state <= ROW_END;
          end else if (emit_i) begin
            state <= STREAM;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_standard_transformer_matrix_streamer.sv
// Bench for the matrix streamer: directed table, hand-written corner sequences, randomized run vs model.
module tb_accelerator_standard_transformer_matrix_streamer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        READY;
  logic [63:0] SIZE_I_IN = '0;
  logic [63:0] SIZE_J_IN = '0;
  logic        WR_ENABLE = 1'b0;
  logic [5:0]  WR_ADDR = '0;
  logic [63:0] WR_DATA = '0;
  logic [63:0] DATA_OUT;
  logic        DATA_I_ENABLE;
  logic        DATA_J_ENABLE;
  logic        DATA_I_REQUEST = 1'b0;
  logic        DATA_J_REQUEST = 1'b0;

  accelerator_standard_transformer_matrix_streamer dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .READY          (READY),
    .SIZE_I_IN      (SIZE_I_IN),
    .SIZE_J_IN      (SIZE_J_IN),
    .WR_ENABLE      (WR_ENABLE),
    .WR_ADDR        (WR_ADDR),
    .WR_DATA        (WR_DATA),
    .DATA_OUT       (DATA_OUT),
    .DATA_I_ENABLE  (DATA_I_ENABLE),
    .DATA_J_ENABLE  (DATA_J_ENABLE),
    .DATA_I_REQUEST (DATA_I_REQUEST),
    .DATA_J_REQUEST (DATA_J_REQUEST)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] mem_m [64];

  typedef struct {
    bit              st;
    int              si;
    int              sj;
    bit              ir;
    bit              jr;
    bit              ei;
    bit              ej;
    bit              er;
    longint unsigned ed;
  } vec_t;
  vec_t tbl [10];

  // Reference model: stream position in row-major terms.
  int          m_mode = 0;  // 0 idle, 1 streaming, 2 reporting completion
  int          m_row, m_col, m_si, m_sj;
  bit          m_await;
  bit          e_i, e_j, e_r;
  logic [63:0] e_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit ei, input bit ej, input bit er);
    chk_bit({tag, ".i_en"}, DATA_I_ENABLE, ei);
    chk_bit({tag, ".j_en"}, DATA_J_ENABLE, ej);
    chk_bit({tag, ".ready"}, READY, er);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit st, input bit ir, input bit jr);
    START          = st;
    DATA_I_REQUEST = ir;
    DATA_J_REQUEST = jr;
  endtask

  task automatic set_size(input int si, input int sj);
    SIZE_I_IN = 64'(si);
    SIZE_J_IN = 64'(sj);
  endtask

  task automatic wr(input int a, input logic [63:0] d);
    WR_ENABLE = 1'b1;
    WR_ADDR   = 6'(a);
    WR_DATA   = d;
    mem_m[a]  = d;
    step();
    WR_ENABLE = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit ir, input bit jr,
                            input logic [63:0] si_in, input logic [63:0] sj_in,
                            input bit we, input int wa, input logic [63:0] wd);
    if (we) mem_m[wa] = wd;
    e_i = 1'b0;
    e_j = 1'b0;
    e_r = 1'b0;
    case (m_mode)
      0: if (st) begin
        m_si = (si_in > 64'd8) ? 8 : int'(si_in);
        m_sj = (sj_in > 64'd8) ? 8 : int'(sj_in);
        if (m_si == 0 || m_sj == 0) begin
          e_r = 1'b1;
          m_mode = 2;
        end else begin
          m_row = 0; m_col = 0; m_await = 1'b0; m_mode = 1;
          e_i = 1'b1; e_j = 1'b1;
        end
      end
      1: begin
        if (ir) begin
          if (m_row < m_si - 1) begin
            m_row++; m_col = 0; m_await = 1'b0;
            e_i = 1'b1; e_j = 1'b1;
          end else begin
            e_r = 1'b1; m_mode = 2;
          end
        end else if (jr && !m_await) begin
          if (m_col < m_sj - 1) begin
            m_col++; e_j = 1'b1;
          end else if (m_row < m_si - 1) begin
            m_await = 1'b1;
          end else begin
            e_r = 1'b1; m_mode = 2;
          end
        end
      end
      default: m_mode = 0;
    endcase
    if (e_j) e_d = mem_m[m_row * 8 + m_col];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rows;
    bit got_ready;
    bit done;
    bit st, ir, jr, we;
    int si, sj, wa;
    logic [63:0] wd;

    tbl[0] = '{1'b1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[3] = '{1'b0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[4] = '{1'b0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[5] = '{1'b0, 2, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10};
    tbl[6] = '{1'b0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11};
    tbl[7] = '{1'b0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12};
    tbl[8] = '{1'b0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12};
    tbl[9] = '{1'b0, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12};

    // Reset state
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.data", DATA_OUT, 64'd0);
    #10 RST = 1'b1;
    step();

    for (int a = 0; a < 64; a++) wr(a, 64'((a / 8) * 10 + (a % 8)));

    // Full 2x3 stream from the table
    for (int k = 0; k < 10; k++) begin
      set_size(tbl[k].si, tbl[k].sj);
      drive(tbl[k].st, tbl[k].ir, tbl[k].jr);
      step();
      chk_out($sformatf("tbl%0d", k), tbl[k].ei, tbl[k].ej, tbl[k].er);
      chk($sformatf("tbl%0d.data", k), DATA_OUT, 64'(tbl[k].ed));
    end
    drive(0, 0, 0);

    // Row clamp: 20 rows requested, 8 streamed
    set_size(20, 1);
    drive(1, 0, 0);
    step();
    rows = 0;
    got_ready = 1'b0;
    for (int c = 0; c < 30 && !got_ready; c++) begin
      if (DATA_I_ENABLE) begin
        chk($sformatf("clamp.row%0d", rows), DATA_OUT, 64'(rows * 10));
        rows++;
      end
      if (READY) got_ready = 1'b1;
      else begin
        drive(0, 1, 0);
        step();
      end
    end
    chk_bit("clamp.ready_seen", got_ready, 1'b1);
    chk("clamp.rows", 64'(rows), 64'd8);
    drive(0, 0, 0);
    step();

    // Zero columns: immediate completion
    set_size(3, 0);
    drive(1, 0, 0);
    step();
    chk_out("zero.first", 1'b0, 1'b0, 1'b1);
    drive(0, 0, 0);
    step();
    chk_out("zero.after", 1'b0, 1'b0, 1'b0);

    // Simultaneous I and J at (0,0)
    set_size(2, 2);
    drive(1, 0, 0);
    step();
    chk_out("simul.start", 1'b1, 1'b1, 1'b0);
    drive(0, 1, 1);
    step();
    chk_out("simul.both", 1'b1, 1'b1, 1'b0);
    chk("simul.data", DATA_OUT, 64'd10);
    drive(0, 0, 1);
    step();
    chk("simul.data2", DATA_OUT, 64'd11);
    step();
    chk_out("simul.done", 1'b0, 1'b0, 1'b1);
    drive(0, 0, 0);
    step();

    // Row end: J requests ignored until an I request
    set_size(2, 2);
    drive(1, 0, 0);
    step();
    drive(0, 0, 1);
    step();
    chk("rowend.data1", DATA_OUT, 64'd1);
    step();
    chk_out("rowend.enter", 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_out($sformatf("rowend.idle%0d", c), 1'b0, 1'b0, 1'b0);
    end
    drive(0, 1, 0);
    step();
    chk_out("rowend.next", 1'b1, 1'b1, 1'b0);
    chk("rowend.data", DATA_OUT, 64'd10);
    step();
    chk_out("rowend.done", 1'b0, 1'b0, 1'b1);
    drive(0, 0, 0);
    step();

    // Write during stream, START ignored mid-stream
    set_size(1, 3);
    drive(1, 0, 0);
    step();
    chk("wr.data0", DATA_OUT, 64'd0);
    drive(0, 0, 0);
    wr(2, 64'hFF);
    set_size(5, 5);
    drive(1, 0, 0);
    step();
    chk_out("wr.start_ignored", 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1);
    step();
    chk("wr.data1", DATA_OUT, 64'd1);
    step();
    chk("wr.data2", DATA_OUT, 64'hFF);
    chk_out("wr.e2", 1'b0, 1'b1, 1'b0);
    step();
    chk_out("wr.done", 1'b0, 1'b0, 1'b1);
    drive(0, 0, 0);
    step();
    wr(2, 64'd2);

    // Asynchronous reset mid-stream
    set_size(2, 3);
    drive(1, 0, 0);
    step();
    drive(0, 0, 1);
    step();
    chk("rst.pre", DATA_OUT, 64'd1);
    drive(0, 0, 0);
    #2 RST = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 1'b0, 1'b0);
    chk("rst.data", DATA_OUT, 64'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk_out($sformatf("rst.hold%0d", c), 1'b0, 1'b0, 1'b0);
    end
    #2 RST = 1'b1;
    set_size(1, 2);
    drive(1, 0, 0);
    step();
    chk_out("rst.restart", 1'b1, 1'b1, 1'b0);
    chk("rst.restart_data", DATA_OUT, 64'd0);
    drive(0, 0, 1);
    step();
    chk("rst.restart_data1", DATA_OUT, 64'd1);
    step();
    chk_out("rst.restart_done", 1'b0, 1'b0, 1'b1);
    drive(0, 0, 0);
    step();

    // Randomized streams against the reference model
    for (int t = 0; t < 40; t++) begin
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        st = (c == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
        si = $urandom_range(0, 10);
        sj = $urandom_range(0, 10);
        ir = ($urandom_range(0, 5) == 0);
        jr = $urandom_range(0, 1) == 1;
        we = ($urandom_range(0, 7) == 0);
        wa = $urandom_range(0, 63);
        wd = {$urandom, $urandom};
        set_size(si, sj);
        drive(st, ir, jr);
        WR_ENABLE = we;
        WR_ADDR   = 6'(wa);
        WR_DATA   = wd;
        model_edge(st, ir, jr, 64'(si), 64'(sj), we, wa, wd);
        step();
        chk_out($sformatf("rnd%0d.c%0d", t, c), e_i, e_j, e_r);
        if (e_j) chk($sformatf("rnd%0d.c%0d.data", t, c), DATA_OUT, e_d);
        if (m_mode == 0) done = 1'b1;
      end
      chk_bit($sformatf("rnd%0d.finished", t), done, 1'b1);
      WR_ENABLE = 1'b0;
      drive(0, 0, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
